// File: rtl/add_sub_sequencer.sv
// Request sequencer for a gate-level ripple adder: registers the adder inputs,
// holds them for SETTLE_CYCLES clocks, then captures sum and flags for the consumer.
module add_sub_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_ci,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_carryout,
    input  logic             adder_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       accept;
    logic       capture;

    assign accept  = (state == IDLE) && in_valid;
    assign capture = (state == SETTLE) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so no comb path from in_valid/out_ready.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_a  <= '0;
            adder_b  <= '0;
            adder_ci <= 1'b0;
        end else if (accept) begin
            adder_a  <= in_a;
            adder_b  <= in_b ^ {WIDTH{op_sub}};
            adder_ci <= op_sub;
        end
    end

    // Zero/negative are registered alongside the sum so they track out_result exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
        end else if (capture) begin
            out_result   <= adder_sum;
            out_carry    <= adder_carryout;
            out_overflow <= adder_overflow;
            out_zero     <= (adder_sum == '0);
            out_negative <= adder_sum[WIDTH-1];
        end
    end

endmodule

// File: doc/add_sub_sequencer.md
# add_sub_sequencer

Control stage that sits directly upstream of the 32-bit gate-level ripple adder `add32Bit`. It accepts add/subtract requests over a valid/ready handshake and drives the adder's `a`, `b` and `ci` inputs from registers. It holds those inputs stable for a fixed number of clock cycles so the gate-delayed ripple can settle, then captures sum, carry, overflow and derived flags into an output register presented on a second valid/ready handshake.

## Interface
- `WIDTH`, default 32: operand and result width. Must match the attached adder instance.
- `SETTLE_CYCLES`, default 4: clock cycles the adder inputs are held before capture. Legal range 1–255. Must cover the adder's worst-case ripple delay at the chosen clock period.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: request present.
- `in_ready`  output  1: block can accept a request.
- `op_sub`  input  1: 0 = A+B, 1 = A−B.
- `in_a`  input  WIDTH: operand A.
- `in_b`  input  WIDTH: operand B.
- `adder_a`  output  WIDTH: to adder `a`.
- `adder_b`  output  WIDTH: to adder `b`.
- `adder_ci`  output  1: to adder `ci`.
- `adder_sum`  input  WIDTH: from adder `sum`.
- `adder_carryout`  input  1: from adder `carryout`.
- `adder_overflow`  input  1: from adder `overflow`.
- `out_valid`  output  1: result held.
- `out_ready`  input  1: consumer takes the result.
- `out_result`  output  WIDTH: captured sum.
- `out_carry`  output  1: captured carryout. For subtract this is 1 = no borrow.
- `out_overflow`  output  1: captured signed overflow.
- `out_zero`  output  1: `out_result` == 0.
- `out_negative`  output  1: `out_result[WIDTH-1]`.

## Operation
- FSM states: IDLE, SETTLE, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - When `in_valid`&&`in_ready`: load `adder_a`←`in_a`, `adder_b`←`in_b` XOR {WIDTH{`op_sub`}}, `adder_ci`←`op_sub`.
  - Load the settle counter with `SETTLE_CYCLES`−1, then go to SETTLE.
- SETTLE:
  - `in_ready`=0, `out_valid`=0.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture `adder_sum`/`adder_carryout`/`adder_overflow` into the output registers, compute zero/negative from the captured sum, and go to DONE.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - Outputs are held bit-stable until `out_valid`&&`out_ready`, then go to IDLE.
  - `in_valid` is ignored in DONE and SETTLE.
- Adder drive registers keep their last value after capture and change only on the next accept.
- `out_*` data registers also persist after the handshake and change only on the next capture.
- Flags come from the adder itself; no internal arithmetic is performed on them. `out_zero` and `out_negative` are derived from the registered result.

## Timing
- Reset (`rst_n` low, any time, any state): immediately state=IDLE and counter=0.
  - All-zero outputs: `adder_a`, `adder_b`, `adder_ci`, `out_result`, `out_carry`, `out_overflow`, `out_zero`, `out_negative`, `out_valid`.
  - `in_ready`=1.
  - Any in-flight transaction is dropped and no `out_valid` is produced for it.
- Latency: request accepted at rising edge k; `adder_*` valid after edge k; capture at edge k+`SETTLE_CYCLES`; `out_valid` high from edge k+`SETTLE_CYCLES`.
- Throughput: one op per `SETTLE_CYCLES`+2 cycles with `out_ready` tied high. There is no accept in the same cycle as the output handshake.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `in_valid`/`out_ready`.
- `SETTLE_CYCLES`=1: SETTLE lasts exactly one cycle.
- Bench configuration: clock period 500 time units, `SETTLE_CYCLES`=4, giving 2000 units of settle time, which exceeds the 32-bit ripple worst case of about 1000 units.

## Test plan
- Add 0x77777777 + 0xBBBBBBBB, `op_sub`=0:
  - `adder_ci`=0.
  - After 4 cycles: `out_result`=0x33333332, carry=1, overflow=0, zero=0, negative=0.
- Subtract 5 − 5, `op_sub`=1:
  - `adder_b`=0xFFFFFFFA, `adder_ci`=1.
  - `out_result`=0, carry=1, overflow=0, zero=1.
- Add 0x7FFFFFFF + 1:
  - `out_result`=0x80000000, overflow=1, negative=1, carry=0.
- Subtract 0 − 1:
  - `out_result`=0xFFFFFFFF, carry=0 (borrow), negative=1, overflow=0.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` with new operands.
  - `out_valid` stays 1, result unchanged, `in_ready`=0, and the new request is not accepted.
  - Raise `out_ready`: IDLE and `in_ready`=1 on the next edge.
- Reset mid-operation:
  - Assert `rst_n`=0 two cycles into SETTLE, between clock edges.
  - Immediately all outputs are 0 and `in_ready`=1.
  - After release, `out_valid` never rises without a new request.
  - A following 1 + 2 yields 3 normally.
